// File: rtl/bw_vcmp_unit_pkg.sv
// rtl/bw_vcmp_unit_pkg.sv - shared types for the BlackWidow vector compare unit
// Contents:
//   cmp_op_t       compare opcode (LT, GE, LE, GT, EQ, NE; 6 and 7 reserved)
//   vcmp_req_t     latched request controls (op, sign, imm select, mask, zero, old)
//   vcmp_state_t   sequencer states
package bw_vcmp_unit_pkg;

  // Upper bound on lanes carried by the request struct; the top checks LANES against it.
  localparam int VCMP_MAX_LANES = 8;

  typedef enum logic [2:0] {
    CMP_LT = 3'd0,
    CMP_GE = 3'd1,
    CMP_LE = 3'd2,
    CMP_GT = 3'd3,
    CMP_EQ = 3'd4,
    CMP_NE = 3'd5
  } cmp_op_t;

  typedef struct packed {
    cmp_op_t                   op;
    logic                      sgn;
    logic                      use_imm;
    logic [VCMP_MAX_LANES-1:0] mask;
    logic                      zero;
    logic [VCMP_MAX_LANES-1:0] old;
  } vcmp_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vcmp_state_t;

endpackage

// File: rtl/bw_vcmp_unit_if.sv
// rtl/bw_vcmp_unit_if.sv - request/result handshake bundle for bw_vcmp_unit
// Signals:
//   req_valid/req_ready   request handshake (issue side)
//   req_op..req_old       request payload, sampled on accept
//   res_valid/res_ready   result handshake (predicate write side)
//   res_pred/any/all      result payload, stable while res_valid
// Modports: slave = the compare unit, master = issue + consumer.
interface bw_vcmp_unit_if #(
  parameter int WID   = 64,
  parameter int LANES = 8
);

  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_op;
  logic                   req_sgn;
  logic                   req_use_imm;
  logic [LANES*WID-1:0]   req_a;
  logic [LANES*WID-1:0]   req_b;
  logic [WID-1:0]         req_imm;
  logic [LANES-1:0]       req_mask;
  logic                   req_zero;
  logic [LANES-1:0]       req_old;
  logic                   res_valid;
  logic                   res_ready;
  logic [LANES-1:0]       res_pred;
  logic                   res_any;
  logic                   res_all;

  modport slave (
    input  req_valid, req_op, req_sgn, req_use_imm, req_a, req_b, req_imm,
           req_mask, req_zero, req_old, res_ready,
    output req_ready, res_valid, res_pred, res_any, res_all
  );

  modport master (
    output req_valid, req_op, req_sgn, req_use_imm, req_a, req_b, req_imm,
           req_mask, req_zero, req_old, res_ready,
    input  req_ready, res_valid, res_pred, res_any, res_all
  );

endinterface

// File: rtl/bw_vcmp_unit_cmp_lane.sv
// rtl/bw_vcmp_unit_cmp_lane.sv - single-lane combinational comparator (module bw_cmp_lane)
// Ports:
//   i_op   compare opcode; reserved codes yield 0
//   i_sgn  1 = two's-complement compare, 0 = unsigned
//   i_a    left operand
//   i_b    right operand
//   o_res  1 when (i_a op i_b) holds
module bw_cmp_lane
  import bw_vcmp_unit_pkg::*;
#(
  parameter int WID = 64
) (
  input  cmp_op_t        i_op,
  input  logic           i_sgn,
  input  logic [WID-1:0] i_a,
  input  logic [WID-1:0] i_b,
  output logic           o_res
);

  logic w_lt;
  logic w_eq;

  // Every relation is derived from one less-than and one equality.
  always_comb begin
    w_eq  = (i_a == i_b);
    w_lt  = i_sgn ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
    o_res = 1'b0;
    case (i_op)
      CMP_LT:  o_res = w_lt;
      CMP_GE:  o_res = ~w_lt;
      CMP_LE:  o_res = w_lt | w_eq;
      CMP_GT:  o_res = ~(w_lt | w_eq);
      CMP_EQ:  o_res = w_eq;
      CMP_NE:  o_res = ~w_eq;
      default: o_res = 1'b0;
    endcase
  end

endmodule

// File: rtl/bw_vcmp_unit.sv
// rtl/bw_vcmp_unit.sv - multi-cycle vector compare producing a masked predicate plus any/all
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    bw_vcmp_unit_if.slave: request in, predicate result out
// Parameters: WID lane width, LANES lanes per request, LPC lanes evaluated per clock.
module bw_vcmp_unit
  import bw_vcmp_unit_pkg::*;
#(
  parameter int WID   = 64,
  parameter int LANES = 8,
  parameter int LPC   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bw_vcmp_unit_if.slave        bus
);

  localparam int NCHUNK = LANES / LPC;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (LANES > 1) ? $clog2(LANES) : 1;

  if (LPC < 1 || (LANES % LPC) != 0) begin : g_bad_lpc
    $error("bw_vcmp_unit: LPC must be positive and divide LANES");
  end
  if (LANES > VCMP_MAX_LANES) begin : g_bad_lanes
    $error("bw_vcmp_unit: LANES exceeds VCMP_MAX_LANES");
  end

  vcmp_state_t          r_state;
  vcmp_state_t          w_next;
  logic                 w_req_ready;
  logic                 w_res_valid;
  logic                 w_accept;
  logic                 w_last;

  vcmp_req_t            r_req;
  logic [LANES*WID-1:0] r_a;
  logic [LANES*WID-1:0] r_b;
  logic [WID-1:0]       r_imm;
  logic [CW-1:0]        r_cnt;
  logic [LANES-1:0]     r_pred;
  logic                 r_any;
  logic                 r_all;

  logic [LANES-1:0]     w_pred_nxt;
  logic                 w_any_nxt;
  logic                 w_all_nxt;

  logic [IW-1:0]        w_idx      [LPC];
  logic [WID-1:0]       w_lane_a   [LPC];
  logic [WID-1:0]       w_lane_b   [LPC];
  logic                 w_lane_res [LPC];

  assign w_accept = bus.req_valid & w_req_ready;
  assign w_last   = (r_cnt == CW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Chunk lanes: lane index cnt*LPC + j; b is replaced by the immediate in broadcast mode.
  for (genvar j = 0; j < LPC; j++) begin : g_lane
    assign w_idx[j]    = IW'(int'(r_cnt) * LPC + j);
    assign w_lane_a[j] = r_a[w_idx[j]*WID +: WID];
    assign w_lane_b[j] = r_req.use_imm ? r_imm : r_b[w_idx[j]*WID +: WID];

    bw_cmp_lane #(
      .WID (WID)
    ) u_lane (
      .i_op  (r_req.op),
      .i_sgn (r_req.sgn),
      .i_a   (w_lane_a[j]),
      .i_b   (w_lane_b[j]),
      .o_res (w_lane_res[j])
    );
  end

  // Only active lanes feed the reductions; inactive lanes take zero or the old bit.
  always_comb begin
    w_pred_nxt = r_pred;
    w_any_nxt  = r_any;
    w_all_nxt  = r_all;
    for (int j = 0; j < LPC; j++) begin
      if (r_req.mask[w_idx[j]]) begin
        w_pred_nxt[w_idx[j]] = w_lane_res[j];
        w_any_nxt            = w_any_nxt | w_lane_res[j];
        w_all_nxt            = w_all_nxt & w_lane_res[j];
      end else begin
        w_pred_nxt[w_idx[j]] = ~r_req.zero & r_req.old[w_idx[j]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
      r_cnt  <= '0;
      r_pred <= '0;
      r_any  <= 1'b0;
      r_all  <= 1'b0;
    end else if (w_accept) begin
      r_req.op      <= cmp_op_t'(bus.req_op);
      r_req.sgn     <= bus.req_sgn;
      r_req.use_imm <= bus.req_use_imm;
      r_req.mask    <= VCMP_MAX_LANES'(bus.req_mask);
      r_req.zero    <= bus.req_zero;
      r_req.old     <= VCMP_MAX_LANES'(bus.req_old);
      r_a           <= bus.req_a;
      r_b           <= bus.req_b;
      r_imm         <= bus.req_imm;
      r_cnt         <= '0;
      // Reduction identities, so an empty mask ends with any=0, all=1.
      r_any         <= 1'b0;
      r_all         <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_cnt  <= r_cnt + CW'(1);
      r_pred <= w_pred_nxt;
      r_any  <= w_any_nxt;
      r_all  <= w_all_nxt;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_pred  = r_pred;
  assign bus.res_any   = r_any;
  assign bus.res_all   = r_all;

endmodule

// File: doc/bw_vcmp_unit.md
# bw_vcmp_unit

Multi-lane, multi-cycle compare unit for the BlackWidow vector datapath. It compares LANES operand pairs, or each lane against a broadcast immediate, under signed or unsigned rules, processing LPC lanes per clock. It produces a per-lane predicate mask with merge or zeroing masking, plus any/all reductions. It sits between vector issue and the predicate register file write port, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WID, 64, lane width in bits
- LANES, 8, lanes per request
- LPC, 2, lanes evaluated per clock; must divide LANES (elaboration-time assertion)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  cmp_op_t: LT=0, GE=1, LE=2, GT=3, EQ=4, NE=5; 6 and 7 reserved
- req_sgn  in  1  1 = signed compare, 0 = unsigned
- req_use_imm  in  1  1 = compare each lane of a against req_imm
- req_a  in  LANES*WID  lane operands a; lane i occupies bits [i*WID +: WID]
- req_b  in  LANES*WID  lane operands b
- req_imm  in  WID  immediate, already extended to WID
- req_mask  in  LANES  lane-active mask
- req_zero  in  1  1 = inactive lanes produce 0; 0 = inactive lanes keep req_old
- req_old  in  LANES  prior predicate value, used for merge
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts the result
- res_pred  out  LANES  predicate result
- res_any  out  1  OR of the compare results over active lanes
- res_all  out  1  AND of the compare results over active lanes

## Operation
- Handshake: a request is accepted on a cycle where req_valid && req_ready. A result is consumed on a cycle where res_valid && res_ready.
- On accept, the unit registers all req_* fields. Inputs are not sampled again until the next accept.
- State machine:
  - IDLE: req_ready=1. On accept → RUN and clear the chunk counter.
  - RUN: req_ready=0. Each cycle evaluates lanes [cnt*LPC +: LPC] and writes those bits of the predicate register. cnt increments each cycle. On the cycle that evaluates the last chunk (cnt == LANES/LPC-1) → DONE.
  - DONE: res_valid=1 and outputs are stable. When res_ready=1 → IDLE.
- Per-lane result rules:
  - Active lane (mask=1): the compare result of a op b (or a op imm), using signed or unsigned comparison per req_sgn.
  - Reserved op: every active lane produces 0.
  - Inactive lane: 0 if req_zero, otherwise req_old[i].
- Reductions are computed over active lanes only:
  - res_any = 0 when no lane is active.
  - res_all = 1 when no lane is active.
  - Merged (inactive) bits never affect the reductions.
- The any/all accumulators are updated per chunk alongside the predicate register.

## Timing
- Latency: the accept cycle, then LANES/LPC RUN cycles. res_valid rises on the clock edge that ends the final RUN cycle. For the defaults, that is 4 cycles after the accept edge.
- Throughput: one request per LANES/LPC+2 cycles at best. There is no overlap; req_ready stays 0 through RUN and DONE.
- Backpressure: DONE holds indefinitely while res_ready=0. res_pred, res_any and res_all must not change while res_valid=1.
- LPC == LANES: RUN lasts exactly one cycle.
- Reset values:
  - state = IDLE, req_ready = 1 (after reset deasserts), res_valid = 0.
  - res_pred = 0, res_any = 0, res_all = 0, counter = 0.
- Reset asserted mid-RUN or in DONE aborts the operation and discards the result. No partial result is ever presented.
- req_valid while not ready is ignored; the requester must hold it.

## Structure
- rfBlackWidowPkg gains:
  - cmp_op_t (3-bit enum with the values above)
  - a vcmp_req_t struct bundling op, sgn, use_imm, mask, zero and old
- Sub-module bw_cmp_lane: combinational WID-bit comparator with inputs op, sgn, a, b and output res. Instantiate it LPC times, selecting operands by chunk index.

## Test plan
- Signed vs unsigned:
  - Stimulus: lane0 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, op=LT, mask=8'h01, zero=1.
  - sgn=1 → res_pred=8'h01, res_any=1, res_all=1.
  - sgn=0 → res_pred=8'h00, res_any=0, res_all=0.
- Immediate mode:
  - Stimulus: a lanes = 0..7, imm=4, op=GE, use_imm=1, mask=8'hFF.
  - Required: res_pred=8'hF0, res_any=1, res_all=0; res_valid on the 4th edge after accept.
- Merge vs zero:
  - Stimulus: all lanes a=b, op=EQ, mask=8'h0F, old=8'hA0.
  - zero=0 → res_pred=8'hAF, res_all=1.
  - zero=1 → res_pred=8'h0F.
- Empty mask and reserved op:
  - mask=0, op=EQ → res_any=0, res_all=1, res_pred=old (merge).
  - op=6, mask=8'hFF → res_pred=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in DONE.
  - Required: outputs stable and req_ready=0 throughout; one cycle after res_ready=1, req_ready=1.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 during the second RUN cycle.
  - Required: res_valid=0 and res_pred=0 immediately. A new request after reset completes with correct results.
